// File: rtl/slave_send_packet_multi_ep_pkg.sv
// Shared constants and types for the multi-endpoint slave transmit packet builder.
// TX control codes and data PIDs mirror the SIE/USB constant headers.
package slave_send_packet_multi_ep_pkg;

  localparam logic [7:0] TX_PACKET_START  = 8'h00;
  localparam logic [7:0] TX_PACKET_STREAM = 8'h01;
  localparam logic [7:0] TX_PACKET_STOP   = 8'h02;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_GNT = 4'd1,
    S_PID_RDY  = 4'd2,
    S_PID_FIN  = 4'd3,
    S_CHK      = 4'd4,
    S_RD_RDY   = 4'd5,
    S_CLR_REN  = 4'd6,
    S_LOAD     = 4'd7,
    S_CLR_WEN  = 4'd8,
    S_TERM_RDY = 4'd9,
    S_TERM_FIN = 4'd10,
    S_FIN      = 4'd11
  } state_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/slave_send_packet_multi_ep_fifo_sel.sv
// Endpoint FIFO selection: NUM_EP:1 data/empty mux and a one-hot read-strobe decoder.
// Out-of-range endpoint selects read as empty and never strobe.
module slave_tx_fifo_sel #(
  parameter int unsigned NUM_EP = 4,
  parameter int unsigned EP_W   = 2
) (
  input  logic [8*NUM_EP-1:0] fifo_data,
  input  logic [NUM_EP-1:0]   fifo_empty,
  input  logic [EP_W-1:0]     ep,
  input  logic                rd,
  output logic [7:0]          data,
  output logic                empty,
  output logic [NUM_EP-1:0]   ren
);

  // Mux and decoder kept in separate processes so the strobe path never loops back into the mux.
  always_comb begin
    data  = '0;
    empty = 1'b1;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (32'(ep) == i) begin
        data  = fifo_data[8*i +: 8];
        empty = fifo_empty[i];
      end
    end
  end

  always_comb begin
    ren = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (32'(ep) == i) ren[i] = rd;
    end
  end

endmodule

// File: rtl/slave_send_packet_multi_ep.sv
// Slave-side USB transmit packet builder: PID + !PID, endpoint FIFO data capped at
// MAX_PKT_BYTES, STOP byte; supports zero-length packets, byte count and abort.
module slave_send_packet_multi_ep
  import slave_send_packet_multi_ep_pkg::*;
#(
  parameter int unsigned NUM_EP        = 4,
  parameter int unsigned EP_W          = 2,
  parameter int unsigned MAX_PKT_BYTES = 64,
  parameter int unsigned CNT_W         = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          PID,
  input  logic [EP_W-1:0]     epSel,
  input  logic                sendPacketWEn,
  output logic                sendPacketRdy,
  input  logic                abort,
  output logic [CNT_W-1:0]    byteCount,
  input  logic [8*NUM_EP-1:0] fifoData,
  input  logic [NUM_EP-1:0]   fifoEmpty,
  output logic [NUM_EP-1:0]   fifoReadEn,
  output logic                SCTxPortReq,
  input  logic                SCTxPortGnt,
  input  logic                SCTxPortRdy,
  output logic                SCTxPortWEn,
  output logic [7:0]          SCTxPortData,
  output logic [7:0]          SCTxPortCntl
);

  state_t            state, state_n;
  logic [3:0]        pid_q, pid_n;
  logic [EP_W-1:0]   ep_q, ep_n;
  logic              rdy_n, req_n, wen_n;
  logic [7:0]        data_n, cntl_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              rd_strobe;
  logic [7:0]        sel_data;
  logic              sel_empty;
  logic [NUM_EP-1:0] sel_ren;

  slave_tx_fifo_sel #(
    .NUM_EP(NUM_EP),
    .EP_W  (EP_W)
  ) u_fifo_sel (
    .fifo_data (fifoData),
    .fifo_empty(fifoEmpty),
    .ep        (ep_q),
    .rd        (rd_strobe),
    .data      (sel_data),
    .empty     (sel_empty),
    .ren       (sel_ren)
  );

  always_comb begin
    state_n   = state;
    pid_n     = pid_q;
    ep_n      = ep_q;
    rdy_n     = sendPacketRdy;
    req_n     = SCTxPortReq;
    wen_n     = 1'b0;
    data_n    = SCTxPortData;
    cntl_n    = SCTxPortCntl;
    cnt_n     = byteCount;
    rd_strobe = 1'b0;

    case (state)
      S_IDLE: begin
        if (sendPacketWEn) begin
          pid_n   = PID;
          ep_n    = epSel;
          cnt_n   = '0;
          rdy_n   = 1'b0;
          req_n   = 1'b1;
          state_n = S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: if (SCTxPortGnt) state_n = S_PID_RDY;
      S_PID_RDY: begin
        if (SCTxPortRdy) begin
          wen_n   = 1'b1;
          data_n  = pid_byte(pid_q);
          cntl_n  = TX_PACKET_START;
          state_n = S_PID_FIN;
        end
      end
      S_PID_FIN: state_n = is_data_pid(pid_q) ? S_CHK : S_FIN;
      S_CHK: begin
        if ((byteCount == CNT_W'(MAX_PKT_BYTES)) || sel_empty) state_n = S_TERM_RDY;
        else                                                    state_n = S_RD_RDY;
      end
      S_RD_RDY: begin
        if (SCTxPortRdy) begin
          rd_strobe = 1'b1;
          state_n   = S_CLR_REN;
        end
      end
      S_CLR_REN: state_n = S_LOAD;
      S_LOAD: begin
        wen_n   = 1'b1;
        data_n  = sel_data;
        cntl_n  = TX_PACKET_STREAM;
        cnt_n   = byteCount + CNT_W'(1);
        state_n = S_CLR_WEN;
      end
      S_CLR_WEN: state_n = S_CHK;
      S_TERM_RDY: begin
        if (SCTxPortRdy) begin
          wen_n   = 1'b1;
          data_n  = 8'h00;
          cntl_n  = TX_PACKET_STOP;
          state_n = S_TERM_FIN;
        end
      end
      S_TERM_FIN: state_n = S_FIN;
      S_FIN: begin
        rdy_n   = 1'b1;
        req_n   = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Abort overrides the step above; once data has gone out, the STOP byte still has to close the packet.
    if (abort && !(state inside {S_IDLE, S_FIN, S_TERM_FIN}) &&
        !((state == S_TERM_RDY) && (byteCount != '0))) begin
      wen_n     = 1'b0;
      rd_strobe = 1'b0;
      data_n    = SCTxPortData;
      cntl_n    = SCTxPortCntl;
      cnt_n     = byteCount;
      state_n   = (byteCount != '0) ? S_TERM_RDY : S_FIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pid_q         <= '0;
      ep_q          <= '0;
      sendPacketRdy <= 1'b1;
      SCTxPortReq   <= 1'b0;
      SCTxPortWEn   <= 1'b0;
      SCTxPortData  <= '0;
      SCTxPortCntl  <= '0;
      fifoReadEn    <= '0;
      byteCount     <= '0;
    end else begin
      state         <= state_n;
      pid_q         <= pid_n;
      ep_q          <= ep_n;
      sendPacketRdy <= rdy_n;
      SCTxPortReq   <= req_n;
      SCTxPortWEn   <= wen_n;
      SCTxPortData  <= data_n;
      SCTxPortCntl  <= cntl_n;
      fifoReadEn    <= sel_ren;
      byteCount     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_slave_send_packet_multi_ep.sv
// Directed and randomized packet sends checked against a queue-based packet model.
module tb_slave_send_packet_multi_ep;

  localparam int NEP   = 3;
  localparam int EPW   = 2;
  localparam int MAXB  = 4;
  localparam int CW    = 10;
  localparam logic [7:0] C_START  = 8'h00;
  localparam logic [7:0] C_STREAM = 8'h01;
  localparam logic [7:0] C_STOP   = 8'h02;
  localparam logic [3:0] P_DATA0  = 4'h3;
  localparam logic [3:0] P_DATA1  = 4'hB;
  localparam logic [3:0] P_ACK    = 4'h2;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      PID;
  logic [EPW-1:0]  epSel;
  logic            sendPacketWEn;
  logic            sendPacketRdy;
  logic            abort;
  logic [CW-1:0]   byteCount;
  logic [8*NEP-1:0] fifoData;
  logic [NEP-1:0]  fifoEmpty;
  logic [NEP-1:0]  fifoReadEn;
  logic            SCTxPortReq;
  logic            SCTxPortGnt;
  logic            SCTxPortRdy;
  logic            SCTxPortWEn;
  logic [7:0]      SCTxPortData;
  logic [7:0]      SCTxPortCntl;

  int checks = 0;
  int failures = 0;
  logic [7:0] fq[NEP][$];

  always #5 clk = ~clk;

  slave_send_packet_multi_ep #(
    .NUM_EP(NEP),
    .EP_W(EPW),
    .MAX_PKT_BYTES(MAXB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PID(PID),
    .epSel(epSel),
    .sendPacketWEn(sendPacketWEn),
    .sendPacketRdy(sendPacketRdy),
    .abort(abort),
    .byteCount(byteCount),
    .fifoData(fifoData),
    .fifoEmpty(fifoEmpty),
    .fifoReadEn(fifoReadEn),
    .SCTxPortReq(SCTxPortReq),
    .SCTxPortGnt(SCTxPortGnt),
    .SCTxPortRdy(SCTxPortRdy),
    .SCTxPortWEn(SCTxPortWEn),
    .SCTxPortData(SCTxPortData),
    .SCTxPortCntl(SCTxPortCntl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the FIFO model pops on a strobe seen during the cycle, data valid after the edge.
  task automatic tick();
    logic [NEP-1:0] ren;
    ren = fifoReadEn;
    @(posedge clk);
    #1;
    for (int i = 0; i < NEP; i++) begin
      if (ren[i] && fq[i].size() > 0) fifoData[8*i +: 8] = fq[i].pop_front();
      fifoEmpty[i] = (fq[i].size() == 0);
    end
  endtask

  task automatic push(input int ep, input logic [7:0] b);
    fq[ep].push_back(b);
    fifoEmpty[ep] = 1'b0;
  endtask

  task automatic run_packet(input logic [3:0] pid, input logic [1:0] ep, input int gnt_delay,
                            input int rdy_low, input int abort_after, input string tag);
    logic [7:0]  snap[$];
    logic [15:0] obs[$];
    logic [15:0] expq[$];
    logic [NEP-1:0] exp_oh;
    int n, len, streams, viol, pulses, rdy_cnt, cmp_len;
    logic prev_rdy, done, abort_pend;

    len = (int'(ep) < NEP) ? fq[ep].size() : 0;
    if (int'(ep) < NEP) snap = fq[ep];
    exp_oh = (int'(ep) < NEP) ? NEP'(1) << ep : '0;
    n = 0;
    if (pid == P_DATA0 || pid == P_DATA1) n = (len < MAXB) ? len : MAXB;
    if (abort_after > 0 && abort_after < n) n = abort_after;
    expq.push_back({C_START, ~pid, pid});
    if (pid == P_DATA0 || pid == P_DATA1) begin
      for (int k = 0; k < n; k++) expq.push_back({C_STREAM, snap[k]});
      expq.push_back({C_STOP, 8'h00});
    end

    rdy_cnt = 0;
    PID = pid;
    epSel = ep;
    sendPacketWEn = 1'b1;
    SCTxPortGnt = 1'b0;
    SCTxPortRdy = (rdy_low == 0);
    prev_rdy = SCTxPortRdy;
    tick();
    rdy_cnt++;
    sendPacketWEn = 1'b0;
    PID = 4'($urandom);
    epSel = 2'($urandom);
    check({tag, "_busy"}, {SCTxPortReq, sendPacketRdy}, 2'b10);

    done = 1'b0; streams = 0; viol = 0; pulses = 0; abort_pend = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (SCTxPortWEn) begin
        obs.push_back({SCTxPortCntl, SCTxPortData});
        if (SCTxPortCntl != C_STREAM && !prev_rdy) viol++;
        if (SCTxPortCntl == C_STREAM) begin
          streams++;
          if (streams == abort_after) abort_pend = 1'b1;
        end
        rdy_cnt = 0;
      end
      if (fifoReadEn != '0) begin
        pulses++;
        if (fifoReadEn != exp_oh || !prev_rdy) viol++;
        rdy_cnt = 0;
      end
      if (sendPacketRdy) begin
        done = 1'b1;
        sendPacketWEn = 1'b0;
        abort = 1'b0;
        SCTxPortGnt = 1'b0;
      end else begin
        sendPacketWEn = (cyc == 2);
        PID = 4'($urandom);
        SCTxPortGnt = (cyc >= gnt_delay);
        abort = abort_pend;
        abort_pend = 1'b0;
        SCTxPortRdy = (rdy_cnt >= rdy_low);
        prev_rdy = SCTxPortRdy;
        tick();
        rdy_cnt++;
      end
    end

    check({tag, "_done"}, done, 1'b1);
    check({tag, "_nbytes"}, obs.size(), expq.size());
    cmp_len = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int k = 0; k < cmp_len; k++) check($sformatf("%s_byte%0d", tag, k), obs[k], expq[k]);
    check({tag, "_count"}, byteCount, n);
    check({tag, "_req"}, SCTxPortReq, 1'b0);
    check({tag, "_strobes"}, pulses, n);
    check({tag, "_ordering"}, viol, 0);
    if (int'(ep) < NEP) check({tag, "_left"}, fq[ep].size(), len - n);
  endtask

  initial begin
    logic [3:0] p;
    logic [1:0] e;
    int nb, ab;

    rst = 1'b1; PID = '0; epSel = '0; sendPacketWEn = 1'b0; abort = 1'b0;
    fifoData = '0; fifoEmpty = '1; SCTxPortGnt = 1'b0; SCTxPortRdy = 1'b0;
    repeat (3) tick();
    check("rst_rdy", sendPacketRdy, 1'b1);
    check("rst_outs", {SCTxPortReq, SCTxPortWEn, SCTxPortData, SCTxPortCntl}, '0);
    check("rst_ren_cnt", {fifoReadEn, byteCount}, '0);
    rst = 1'b0;
    tick();

    run_packet(P_ACK, 2'd0, 3, 0, 0, "ack");
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
    run_packet(P_DATA0, 2'd2, 1, 0, 0, "data0_ep2");
    for (int k = 1; k <= 6; k++) push(0, 8'(k));
    run_packet(P_DATA1, 2'd0, 0, 0, 0, "maxpkt");
    run_packet(P_DATA1, 2'd1, 2, 1, 0, "zlp");
    push(2, 8'hA1); push(2, 8'hB2); push(2, 8'hC3);
    run_packet(P_DATA0, 2'd2, 0, 5, 0, "rdy_slow");
    push(0, 8'h77); push(0, 8'h88);
    run_packet(P_DATA0, 2'd0, 1, 1, 2, "abort");
    run_packet(P_DATA1, 2'd3, 0, 0, 0, "ep_oob");

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {sendPacketRdy, SCTxPortReq, SCTxPortWEn}, 3'b100);

    push(1, 8'h5A); push(1, 8'h6B);
    PID = P_DATA0; epSel = 2'd1; sendPacketWEn = 1'b1; SCTxPortGnt = 1'b1; SCTxPortRdy = 1'b1;
    tick();
    sendPacketWEn = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_rdy", sendPacketRdy, 1'b1);
    check("midrst_outs", {SCTxPortReq, SCTxPortWEn, SCTxPortData, SCTxPortCntl}, '0);
    check("midrst_ren_cnt", {fifoReadEn, byteCount}, '0);
    rst = 1'b0; SCTxPortGnt = 1'b0; SCTxPortRdy = 1'b0;
    for (int i = 0; i < NEP; i++) fq[i].delete();
    tick();

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 4))
        0: p = P_DATA0;
        1, 2: p = P_DATA1;
        default: p = 4'($urandom);
      endcase
      e = 2'($urandom_range(0, 3));
      if (int'(e) < NEP) begin
        if (fq[e].size() > 6) fq[e].delete();
        nb = $urandom_range(0, 5);
        for (int k = 0; k < nb; k++) push(int'(e), 8'($urandom));
        fifoEmpty[e] = (fq[e].size() == 0);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_packet(p, e, $urandom_range(0, 3), $urandom_range(0, 2), ab, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
